// File: rtl/serial_tx_pkg.sv
// Shared types and width helpers for the serial_tx transmitter and its bit timer.
package serial_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam int MIN_CNT_WIDTH = 1;

  // Counter width for values 0..count-1, never narrower than one bit.
  function automatic int cnt_width(input int count);
    int w;
    w = $clog2(count);
    if (w < MIN_CNT_WIDTH) begin
      w = MIN_CNT_WIDTH;
    end else begin
      w = w;
    end
    return w;
  endfunction

endpackage

// File: rtl/serial_tx_bit.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each line bit.
module bit_timer
  import serial_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic restart,
  output logic tick
);

  localparam int CW = cnt_width(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [CW-1:0] cnt_r;

  // Cycle counter; restart pins it at zero so a new bit always starts a full period.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= '0;
    end else if (en) begin
      if (restart || (cnt_r == CNT_LAST)) begin
        cnt_r <= '0;
      end else begin
        cnt_r <= cnt_r + CNT_ONE;
      end
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign tick = (cnt_r == CNT_LAST);

endmodule

// File: rtl/serial_tx.sv
// UART-style parallel-to-serial transmitter: start 0, N data bits LSB first, stop 1.
module serial_tx
  import serial_tx_pkg::*;
#(
  parameter int N            = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [N-1:0] tx_data,
  input  logic         tx_valid,
  output logic         tx_ready,
  output logic         tx,
  output logic         busy,
  output logic         done
);

  localparam int IW = cnt_width(N);
  localparam logic [IW-1:0] IDX_LAST = IW'(N - 1);
  localparam logic [IW-1:0] IDX_ONE  = IW'(1);

  tx_state_t     state_r, state_s;
  logic [N-1:0]  shift_r, shift_s;
  logic [IW-1:0] idx_r, idx_s;
  logic          tx_s;
  logic          done_s;
  logic          tick_s;
  logic          accept_s;
  logic          timer_restart_s;

  assign tx_ready        = (state_r == IDLE) & en & ~rst;
  assign accept_s        = tx_valid & tx_ready;
  assign busy            = (state_r != IDLE);
  assign timer_restart_s = (state_r == IDLE);

  bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .restart(timer_restart_s),
    .tick   (tick_s)
  );

  // Next-state, next line value, shifter and bit index.
  always_comb begin
    state_s = state_r;
    shift_s = shift_r;
    idx_s   = idx_r;
    tx_s    = tx;
    done_s  = 1'b0;
    case (state_r)
      IDLE: begin
        tx_s = 1'b1;
        if (accept_s) begin
          state_s = START;
          shift_s = tx_data;
          idx_s   = '0;
          tx_s    = 1'b0;
        end else begin
          state_s = IDLE;
        end
      end
      START: begin
        if (tick_s) begin
          state_s = DATA;
          tx_s    = shift_r[0];
          shift_s = shift_r >> 1'b1;
        end else begin
          state_s = START;
        end
      end
      DATA: begin
        // The line already shows bit idx; on wrap either present the next bit or the stop bit.
        if (tick_s) begin
          if (idx_r == IDX_LAST) begin
            state_s = STOP;
            tx_s    = 1'b1;
          end else begin
            idx_s   = idx_r + IDX_ONE;
            tx_s    = shift_r[0];
            shift_s = shift_r >> 1'b1;
          end
        end else begin
          state_s = DATA;
        end
      end
      STOP: begin
        tx_s = 1'b1;
        if (tick_s) begin
          state_s = IDLE;
          done_s  = 1'b1;
        end else begin
          state_s = STOP;
        end
      end
      default: begin
        state_s = IDLE;
        tx_s    = 1'b1;
      end
    endcase
  end

  // State and datapath registers; en low freezes everything including a pending done.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      shift_r <= '0;
      idx_r   <= '0;
      tx      <= 1'b1;
      done    <= 1'b0;
    end else if (en) begin
      state_r <= state_s;
      shift_r <= shift_s;
      idx_r   <= idx_s;
      tx      <= tx_s;
      done    <= done_s;
    end else begin
      state_r <= state_r;
      shift_r <= shift_r;
      idx_r   <= idx_r;
      tx      <= tx;
      done    <= done;
    end
  end

endmodule

// File: tb/tb_serial_tx.sv
// Directed bench for serial_tx: reset/handshake vector table plus frame, stall, abort and degenerate sequences.
module tb_serial_tx;

  logic       clk = 1'b0;
  logic       rst, en, tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready, tx, busy, done;

  logic       d_rst, d_en, d_valid;
  logic [0:0] d_data;
  logic       d_ready, d_tx, d_busy, d_done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_tx #(.N(8), .CLKS_PER_BIT(4)) dut (
    .clk(clk), .rst(rst), .en(en), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx(tx), .busy(busy), .done(done)
  );

  serial_tx #(.N(1), .CLKS_PER_BIT(1)) dut_min (
    .clk(clk), .rst(d_rst), .en(d_en), .tx_data(d_data), .tx_valid(d_valid),
    .tx_ready(d_ready), .tx(d_tx), .busy(d_busy), .done(d_done)
  );

  typedef struct {
    logic       rst, en, valid;
    logic [7:0] data;
    logic       tx, busy, done, ready;
  } vec_t;

  vec_t tbl [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic frame_bit(input logic [7:0] d, input int c);
    int b;
    b = c / 4;
    if (b == 0) return 1'b0;
    else if (b == 9) return 1'b1;
    else return d[b-1];
  endfunction

  // Sends d and checks each of the 40 frame cycles; optional stall or mid-frame reset.
  task automatic send(input logic [7:0] d, input logic [7:0] next_d, input logic next_v,
                      input int stall_at, input int stall_len, input int abort_at);
    int   busy_cycles;
    logic exp;
    busy_cycles = 0;
    check("ready_before_send", tx_ready, 1);
    tx_valid = 1'b1;
    tx_data  = d;
    step();
    tx_data  = next_d;
    tx_valid = next_v;
    for (int c = 0; c < 40; c++) begin
      exp = frame_bit(d, c);
      check("tx_bit", tx, exp);
      check("busy_in_frame", busy, 1);
      check("done_in_frame", done, 0);
      if (busy) busy_cycles++;
      if (c == abort_at) begin
        rst = 1'b1;
        step();
        check("abort_tx", tx, 1);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_ready_in_rst", tx_ready, 0);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
          step();
          check("after_abort_done", done, 0);
          check("after_abort_tx", tx, 1);
          check("after_abort_busy", busy, 0);
        end
        return;
      end
      if (c == stall_at) begin
        en = 1'b0;
        for (int s = 0; s < stall_len; s++) begin
          step();
          check("stall_tx", tx, exp);
          check("stall_busy", busy, 1);
          check("stall_ready", tx_ready, 0);
          if (busy) busy_cycles++;
        end
        en = 1'b1;
      end
      step();
    end
    check("frame_len", busy_cycles, 40 + stall_len);
    check("idle_tx", tx, 1);
    check("idle_busy", busy, 0);
    check("done_pulse", done, 1);
    check("idle_ready", tx_ready, 1);
    if (!next_v) begin
      step();
      check("done_one_cycle", done, 0);
      check("still_idle", busy, 0);
    end
  endtask

  logic [2:0] min_exp [5];

  initial begin
    rst = 1'b1; en = 1'b1; tx_valid = 1'b1; tx_data = 8'hA5;
    d_rst = 1'b1; d_en = 1'b1; d_valid = 1'b0; d_data = 1'b0;

    // rst, en, valid, data -> tx, busy, done, ready (sampled after the edge)
    tbl[0] = '{1'b1, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[4] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{1'b0, 1'b0, 1'b1, 8'h5A, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[6] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1};

    for (int i = 0; i < 7; i++) begin
      rst = tbl[i].rst; en = tbl[i].en; tx_valid = tbl[i].valid; tx_data = tbl[i].data;
      step();
      check("vec_tx", tx, tbl[i].tx);
      check("vec_busy", busy, tbl[i].busy);
      check("vec_done", done, tbl[i].done);
      check("vec_ready", tx_ready, tbl[i].ready);
    end

    send(8'hA5, 8'hFF, 1'b0, -1, 0, -1);
    send(8'h00, 8'hFF, 1'b1, -1, 0, -1);
    send(8'hFF, 8'h00, 1'b0, -1, 0, -1);
    send(8'h3C, 8'h00, 1'b0, 17, 7, -1);
    send(8'hC3, 8'h00, 1'b0, -1, 0, 25);
    send(8'h81, 8'h00, 1'b0, -1, 0, -1);

    // Degenerate N=1, CLKS_PER_BIT=1: {tx, busy, done} per cycle after accept.
    min_exp[0] = 3'b010;
    min_exp[1] = 3'b110;
    min_exp[2] = 3'b110;
    min_exp[3] = 3'b101;
    min_exp[4] = 3'b100;
    d_rst = 1'b0;
    step();
    check("min_ready", d_ready, 1);
    check("min_idle_tx", d_tx, 1);
    d_valid = 1'b1;
    d_data  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      d_valid = 1'b0;
      check("min_tx", d_tx, min_exp[i][2]);
      check("min_busy", d_busy, min_exp[i][1]);
      check("min_done", d_done, min_exp[i][0]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_tx.md
Name: serial_tx

Overview:
Parallel-to-serial transmitter for the elements catalog. It is the far end of a deserializing receiver link. It accepts an N-bit word over a valid/ready handshake and shifts it out on a single line as a UART-style frame: start bit 0, N data bits LSB first, stop bit 1. Each bit is held for CLKS_PER_BIT clock cycles. It sits between a register/datapath source and an off-block serial line.

Parameters:
N, 8, data word width in bits (N >= 1)
CLKS_PER_BIT, 4, clock cycles each line bit is held (>= 1)

Ports:
clk  input  1  single clock; all state updates on rising edge
rst  input  1  reset, synchronous and active-high
en  input  1  global enable; low freezes all state (counters, shifter, FSM)
tx_data  input  N  parallel word to transmit
tx_valid  input  1  source has a word on tx_data
tx_ready  output  1  block can accept a word this cycle
tx  output  1  serial line; idles high
busy  output  1  frame in progress (START, DATA or STOP)
done  output  1  one-cycle pulse when the stop bit completes

Behaviour:
- Reset (rst=1 at a rising edge), regardless of en or current state:
  - state=IDLE, tx=1, busy=0, done=0.
  - Shift register and counters are cleared.
  - An in-flight frame is abandoned; no done pulse is produced.
- tx_ready = (state==IDLE) & en & ~rst. It is combinational from registered state.
- Handshake:
  - A word is accepted at the edge where tx_valid & tx_ready are both 1.
  - tx_data is captured into the shift register at that edge. The source may change tx_data afterwards.
  - tx_valid with tx_ready=0 has no effect. The source holds the word until accepted.
- FSM states are IDLE, START, DATA and STOP. All transitions require en=1.
  - IDLE -> START on accept.
  - START -> DATA after CLKS_PER_BIT cycles.
  - DATA -> STOP after N bits of CLKS_PER_BIT cycles each.
  - STOP -> IDLE after CLKS_PER_BIT cycles.
- Line value is registered and valid from the edge that enters each state:
  - IDLE: tx=1.
  - START: tx=0.
  - DATA: tx=shift[0]. The shift register shifts right by one and the bit index increments each time the cycle counter wraps.
  - STOP: tx=1.
- Cycle counter is $clog2(CLKS_PER_BIT) bits wide, minimum 1, counting 0..CLKS_PER_BIT-1. Bit index is $clog2(N) bits wide, minimum 1, counting 0..N-1.
- Latency and frame length:
  - Accept at edge k: tx falls immediately after edge k.
  - Frame occupies exactly (N+2)*CLKS_PER_BIT cycles.
  - Return to IDLE happens at edge k+(N+2)*CLKS_PER_BIT.
- done=1 for exactly the one cycle following the STOP->IDLE edge. busy=1 exactly while state != IDLE.
- Back-to-back: if tx_valid stays high, the next word is accepted at the first edge in IDLE. This gives exactly one idle cycle (tx=1) between frames. done and tx_ready are both high during that cycle.
- en=0 mid-frame:
  - tx, state, counters and shifter hold their values.
  - The frame stretches by the number of disabled cycles.
  - done, if pending, holds its value.
- CLKS_PER_BIT=1: one cycle per bit, and the counter logic still works. N=1: DATA lasts one bit.

Decomposition:
- Package serial_tx_pkg:
  - State enum tx_state_t {IDLE, START, DATA, STOP}.
  - Localparam helpers for counter widths.
- One sub-module, bit_timer: parameterised by CLKS_PER_BIT. Inputs clk, rst, en and a restart signal; output tick, asserted when the count reaches CLKS_PER_BIT-1.
- The FSM, shifter and bit index stay in serial_tx.

Test Plan:
- Reset check: rst=1 for 2 cycles with tx_valid=1, then release -> during rst tx=1, busy=0, done=0, tx_ready=0. First cycle after release tx_ready=1 and no word accepted under rst.
- Single frame, N=8, CLKS_PER_BIT=4, send 0xA5 -> tx holds 0,1,0,1,0,0,1,0,1,1 for 4 cycles each (40 cycles). busy=1 for those 40 cycles. done=1 for 1 cycle after. tx_data changed to 0xFF right after accept does not alter the output.
- Back-to-back 0x00 then 0xFF with tx_valid held -> 40-cycle frame, 1 idle cycle with tx=1, done=1, tx_ready=1, then 40-cycle frame with data bits all 1.
- Enable stall: send 0x3C, drop en for 7 cycles during bit 3 -> tx and state frozen. Frame length 47 cycles. Bit sequence unchanged: 0,0,0,1,1,1,1,0,0,1.
- Reset mid-frame: rst=1 during DATA bit 5 -> next cycle tx=1, state IDLE, busy=0, no done pulse. A following 0x81 send produces a clean frame.
- Degenerate parameters N=1, CLKS_PER_BIT=1, send 1 -> tx=0,1,1 over 3 cycles, then done pulse.
